multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the MIPS datapath. Decodes addu, subu, or, ori, lui, lw, sw, beq, j, jal, jr and nop.
- Sequences one shared ALU and one unified memory through the FETCH/DECODE/EXEC/MEM/WB phases.
- Stalls on a memory ready handshake and raises a timeout error if ready never arrives.
- Sits between the instruction register fields and the datapath muxes/write enables.

---
 rtl/multicycle_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM with memory-ready stall and timeout
//
// Purpose:
//   Sequences a shared ALU and a unified memory through FETCH/DECODE/EXEC/MEM/WB
//   for addu, subu, or, ori, lui, lw, sw, beq, j, jal, jr and nop. Memory phases
//   stall on mem_ready_i; a stall reaching MAX_WAIT cycles aborts the access and
//   sets the sticky timeout flag.
//   instr_done_o and illegal_o are registered: each pulses in the cycle after the
//   retiring (or rejecting) cycle, i.e. in the first cycle of the next FETCH.
//
// Optional feature macro: BNEZALC_EN
//   Defined: op=000001 with rt=10011 decodes as bnezalc (unconditional link to
//   $31, branch taken when rt_nez_i). Undefined: that encoding is illegal.
//
// Ports:
//   clk_i, reset_n_i        clock (rising edge), asynchronous active-low reset
//   op_i, func_i, rt_i      instruction register fields
//   zero_i, rt_nez_i        datapath status (ALU zero, GPR[rt] != 0)
//   mem_ready_i             memory completes the current access this cycle
//   ir_we_o, pc_we_o        IR / PC write enables; pc_src_o selects the PC source
//   mem_rd_o, mem_we_o      memory requests; addr_sel_o selects PC or ALUOut
//   reg_we_o                GPR write; reg_dst_o / wd_sel_o select target and data
//   alu_srca_o, alu_srcb_o  ALU operand selects; alu_ctrl_o function; sign_ext_o
//   state_o                 FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
//   instr_done_o, illegal_o one-cycle pulses; timeout_o sticky until reset

module multicycle_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  input  logic [4:0] rt_i,
  input  logic       zero_i,
  input  logic       rt_nez_i,
  input  logic       mem_ready_i,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_src_o,
  output logic       mem_rd_o,
  output logic       mem_we_o,
  output logic       addr_sel_o,
  output logic       reg_we_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] wd_sel_o,
  output logic       alu_srca_o,
  output logic [1:0] alu_srcb_o,
  output logic [2:0] alu_ctrl_o,
  output logic       sign_ext_o,
  output logic [2:0] state_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic       timeout_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_ILLEGAL, C_NOP, C_RTYPE, C_IMM, C_LW, C_SW,
    C_BEQ, C_J, C_JAL, C_JR, C_BNEZALC
  } class_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_NOP  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_OR   = 6'b100101;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;

  // The access is aborted on the wait cycle that would bring the count to MAX_WAIT.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;
  logic       illegal_q, illegal_d;
  logic       done_q, done_d;

  class_e     cls;
  logic [2:0] alu_op;

  logic ir_we, pc_we, mem_rd, mem_we, reg_we;

`ifdef BNEZALC_EN
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [4:0] RT_BNEZALC = 5'b10011;
`else
  logic unused_bnezalc;
  assign unused_bnezalc = ^{rt_i, rt_nez_i};
`endif

  // Instruction class from the IR fields; IR is stable from DECODE onwards.
  always_comb begin
    cls    = C_ILLEGAL;
    alu_op = ALU_ADD;
    case (op_i)
      OP_SPECIAL: begin
        case (func_i)
          FN_NOP:  cls = C_NOP;
          FN_ADDU: begin cls = C_RTYPE; alu_op = ALU_ADD; end
          FN_SUBU: begin cls = C_RTYPE; alu_op = ALU_SUB; end
          FN_OR:   begin cls = C_RTYPE; alu_op = ALU_OR;  end
          FN_JR:   cls = C_JR;
          default: cls = C_ILLEGAL;
        endcase
      end
      OP_ORI: begin cls = C_IMM; alu_op = ALU_OR;  end
      OP_LUI: begin cls = C_IMM; alu_op = ALU_LUI; end
      OP_LW:  cls = C_LW;
      OP_SW:  cls = C_SW;
      OP_BEQ: cls = C_BEQ;
      OP_J:   cls = C_J;
      OP_JAL: cls = C_JAL;
`ifdef BNEZALC_EN
      OP_REGIMM: begin
        if (rt_i == RT_BNEZALC) cls = C_BNEZALC;
      end
`endif
      default: cls = C_ILLEGAL;
    endcase
  end

  // Next state, wait counter and status flags. The counter defaults to zero so
  // that any state change (and any mem_ready) clears it.
  always_comb begin
    state_d   = state_q;
    wait_d    = 8'd0;
    timeout_d = timeout_q;
    illegal_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready_i) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        case (cls)
          C_ILLEGAL: begin illegal_d = 1'b1; state_d = S_FETCH; end
          C_NOP:     begin done_d    = 1'b1; state_d = S_FETCH; end
          default:   state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          C_RTYPE, C_IMM: state_d = S_WB;
          C_LW, C_SW:     state_d = S_MEM;
          C_BEQ, C_J, C_JAL, C_JR, C_BNEZALC: begin
            done_d  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready_i) begin
          if (cls == C_LW) begin
            state_d = S_WB;
          end else begin
            done_d  = (cls == C_SW);
            state_d = S_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        done_d  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  // Datapath controls from state and instruction class.
  always_comb begin
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src_o   = 2'b00;
    mem_rd     = 1'b0;
    mem_we     = 1'b0;
    addr_sel_o = 1'b0;
    reg_we     = 1'b0;
    reg_dst_o  = 2'b00;
    wd_sel_o   = 2'b00;
    alu_srca_o = 1'b0;
    alu_srcb_o = 2'b00;
    alu_ctrl_o = ALU_ADD;
    sign_ext_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd     = 1'b1;
        alu_srcb_o = 2'b01;
        if (mem_ready_i) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_DECODE: begin
        // Branch target pc+4 + (imm<<2) is precomputed into ALUOut here.
        alu_srcb_o = 2'b11;
        sign_ext_o = 1'b1;
      end
      S_EXEC: begin
        case (cls)
          C_RTYPE: begin
            alu_srca_o = 1'b1;
            alu_ctrl_o = alu_op;
          end
          C_IMM: begin
            alu_srca_o = 1'b1;
            alu_srcb_o = 2'b10;
            alu_ctrl_o = alu_op;
          end
          C_LW, C_SW: begin
            alu_srca_o = 1'b1;
            alu_srcb_o = 2'b10;
            sign_ext_o = 1'b1;
          end
          C_BEQ: begin
            alu_srca_o = 1'b1;
            alu_ctrl_o = ALU_SUB;
            pc_we      = zero_i;
            pc_src_o   = 2'b01;
          end
          C_J: begin
            pc_we    = 1'b1;
            pc_src_o = 2'b10;
          end
          C_JAL: begin
            pc_we     = 1'b1;
            pc_src_o  = 2'b10;
            reg_we    = 1'b1;
            reg_dst_o = 2'b10;
            wd_sel_o  = 2'b10;
          end
          C_JR: begin
            pc_we    = 1'b1;
            pc_src_o = 2'b11;
          end
`ifdef BNEZALC_EN
          C_BNEZALC: begin
            pc_we     = rt_nez_i;
            pc_src_o  = 2'b01;
            reg_we    = 1'b1;
            reg_dst_o = 2'b10;
            wd_sel_o  = 2'b10;
          end
`endif
          default: ;
        endcase
      end
      S_MEM: begin
        addr_sel_o = 1'b1;
        mem_rd     = (cls == C_LW);
        mem_we     = (cls == C_SW);
      end
      S_WB: begin
        reg_we = 1'b1;
        case (cls)
          C_LW:    begin reg_dst_o = 2'b00; wd_sel_o = 2'b01; end
          C_RTYPE: begin reg_dst_o = 2'b01; wd_sel_o = 2'b00; end
          default: begin reg_dst_o = 2'b00; wd_sel_o = 2'b00; end
        endcase
      end
      default: ;
    endcase
  end

  // Reset forces every enable low even though the held state is FETCH.
  assign ir_we_o  = ir_we  & reset_n_i;
  assign pc_we_o  = pc_we  & reset_n_i;
  assign mem_rd_o = mem_rd & reset_n_i;
  assign mem_we_o = mem_we & reset_n_i;
  assign reg_we_o = reg_we & reset_n_i;

  assign state_o      = state_q;
  assign instr_done_o = done_q;
  assign illegal_o    = illegal_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, func;
  logic [4:0] rt;
  logic       zero, rt_nez, mem_ready;
  logic       ir_we, pc_we, mem_rd, mem_we, addr_sel, reg_we;
  logic [1:0] pc_src, reg_dst, wd_sel, alu_srcb;
  logic       alu_srca, sign_ext;
  logic [2:0] alu_ctrl, state;
  logic       instr_done, illegal, timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MAX_WAIT(15)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .op_i(op), .func_i(func), .rt_i(rt),
    .zero_i(zero), .rt_nez_i(rt_nez), .mem_ready_i(mem_ready),
    .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_src_o(pc_src),
    .mem_rd_o(mem_rd), .mem_we_o(mem_we), .addr_sel_o(addr_sel),
    .reg_we_o(reg_we), .reg_dst_o(reg_dst), .wd_sel_o(wd_sel),
    .alu_srca_o(alu_srca), .alu_srcb_o(alu_srcb), .alu_ctrl_o(alu_ctrl),
    .sign_ext_o(sign_ext), .state_o(state),
    .instr_done_o(instr_done), .illegal_o(illegal), .timeout_o(timeout)
  );

  typedef struct packed {
    logic [2:0] state;
    logic       ir_we, pc_we;
    logic [1:0] pc_src;
    logic       mem_rd, mem_we, addr_sel, reg_we;
    logic [1:0] reg_dst, wd_sel;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [2:0] alu_ctrl;
    logic       sign_ext, instr_done, illegal, timeout;
  } snap_t;

  typedef struct {
    snap_t v;
    snap_t m;
    logic  rdy;
    logic  zr;
    logic  nez;
    string tag;
  } rec_t;

  rec_t  sbq[$];
  snap_t ev, em;
  logic  pend_done = 1'b0;
  logic  pend_ill  = 1'b0;
  logic  exp_to    = 1'b0;
  logic  zr_s      = 1'b0;
  logic  nez_s     = 1'b0;

  function automatic snap_t observe();
    snap_t s;
    s.state = state; s.ir_we = ir_we; s.pc_we = pc_we; s.pc_src = pc_src;
    s.mem_rd = mem_rd; s.mem_we = mem_we; s.addr_sel = addr_sel; s.reg_we = reg_we;
    s.reg_dst = reg_dst; s.wd_sel = wd_sel; s.alu_srca = alu_srca; s.alu_srcb = alu_srcb;
    s.alu_ctrl = alu_ctrl; s.sign_ext = sign_ext; s.instr_done = instr_done;
    s.illegal = illegal; s.timeout = timeout;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start an expected cycle: enables and pulses are always checked (default 0).
  task automatic ex(input logic [2:0] st);
    ev = '0; em = '0;
    ev.state = st; em.state = '1;
    em.ir_we = 1'b1; em.pc_we = 1'b1; em.mem_rd = 1'b1; em.mem_we = 1'b1; em.reg_we = 1'b1;
    em.instr_done = 1'b1; em.illegal = 1'b1; em.timeout = 1'b1;
    ev.instr_done = pend_done; ev.illegal = pend_ill; ev.timeout = exp_to;
    pend_done = 1'b0; pend_ill = 1'b0;
  endtask

  task automatic push(input string tag, input logic rdy);
    rec_t r;
    r.v = ev; r.m = em; r.rdy = rdy; r.zr = zr_s; r.nez = nez_s; r.tag = tag;
    sbq.push_back(r);
  endtask

  task automatic set_pc(input logic we, input logic [1:0] src);
    ev.pc_we = we; ev.pc_src = src; em.pc_src = '1;
  endtask

  task automatic set_reg(input logic [1:0] dst, input logic [1:0] wd);
    ev.reg_we = 1'b1; ev.reg_dst = dst; ev.wd_sel = wd; em.reg_dst = '1; em.wd_sel = '1;
  endtask

  // care = {srca, srcb, ctrl, sign_ext}
  task automatic set_alu(input logic [3:0] care, input logic a, input logic [1:0] b,
                         input logic [2:0] c, input logic sx);
    ev.alu_srca = a; ev.alu_srcb = b; ev.alu_ctrl = c; ev.sign_ext = sx;
    em.alu_srca = care[3]; em.alu_srcb = {2{care[2]}};
    em.alu_ctrl = {3{care[1]}}; em.sign_ext = care[0];
  endtask

  task automatic f_exp(input string tag, input logic rdy);
    ex(3'd0);
    ev.mem_rd = 1'b1; em.addr_sel = 1'b1;
    set_alu(4'b1110, 1'b0, 2'b01, 3'b000, 1'b0);
    if (rdy) begin
      ev.ir_we = 1'b1;
      set_pc(1'b1, 2'b00);
    end
    push(tag, rdy);
  endtask

  task automatic d_exp(input string tag);
    ex(3'd1);
    set_alu(4'b1101, 1'b0, 2'b11, 3'b000, 1'b1);
    push(tag, 1'b1);
  endtask

  task automatic m_exp(input string tag, input logic rd, input logic rdy);
    ex(3'd3);
    ev.mem_rd = rd; ev.mem_we = ~rd; ev.addr_sel = 1'b1; em.addr_sel = 1'b1;
    push(tag, rdy);
  endtask

  task automatic e_mem(input string tag);
    ex(3'd2);
    set_alu(4'b0111, 1'b0, 2'b10, 3'b000, 1'b1);
    push(tag, 1'b1);
  endtask

  task automatic drain();
    rec_t r;
    logic [$bits(snap_t)-1:0] ov, vv, mv;
    while (sbq.size() > 0) begin
      r = sbq.pop_front();
      mem_ready = r.rdy; zero = r.zr; rt_nez = r.nez;
      @(negedge clk);
      ov = observe(); vv = r.v; mv = r.m;
      checks++;
      assert ((ov & mv) === (vv & mv)) else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h care=%h", r.tag, ov, vv, mv);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic rtype(input string t, input logic [5:0] fn, input logic [2:0] ctrl);
    op = 6'b000000; func = fn;
    f_exp({t, "_f"}, 1'b1);
    d_exp({t, "_d"});
    ex(3'd2); set_alu(4'b1110, 1'b1, 2'b00, ctrl, 1'b0); push({t, "_e"}, 1'b1);
    ex(3'd4); set_reg(2'b01, 2'b00); push({t, "_w"}, 1'b1);
    pend_done = 1'b1;
    drain();
  endtask

  task automatic imm(input string t, input logic [5:0] opc, input logic [2:0] ctrl);
    op = opc; func = 6'b000000;
    f_exp({t, "_f"}, 1'b1);
    d_exp({t, "_d"});
    ex(3'd2); set_alu(4'b0111, 1'b0, 2'b10, ctrl, 1'b0); push({t, "_e"}, 1'b1);
    ex(3'd4); set_reg(2'b00, 2'b00); push({t, "_w"}, 1'b1);
    pend_done = 1'b1;
    drain();
  endtask

  task automatic jump(input string t, input logic [5:0] opc, input logic [5:0] fn,
                      input logic [1:0] src, input logic link);
    op = opc; func = fn;
    f_exp({t, "_f"}, 1'b1);
    d_exp({t, "_d"});
    ex(3'd2); set_pc(1'b1, src);
    if (link) set_reg(2'b10, 2'b10);
    push({t, "_e"}, 1'b1);
    pend_done = 1'b1;
    drain();
  endtask

  task automatic beq(input string t, input logic z);
    op = 6'b000100; func = 6'b000000; zr_s = z;
    f_exp({t, "_f"}, 1'b1);
    d_exp({t, "_d"});
    ex(3'd2); set_alu(4'b0010, 1'b0, 2'b00, 3'b001, 1'b0); set_pc(z, 2'b01);
    push({t, "_e"}, 1'b1);
    pend_done = 1'b1;
    drain();
    zr_s = 1'b0;
  endtask

  task automatic bad(input string t, input logic [5:0] opc, input logic [5:0] fn,
                     input logic [4:0] rtv);
    op = opc; func = fn; rt = rtv;
    f_exp({t, "_f"}, 1'b1);
    d_exp({t, "_d"});
    pend_ill = 1'b1;
    drain();
    rt = 5'd0;
  endtask

  initial begin
    reset_n = 1'b0; op = '0; func = '0; rt = '0;
    zero = 1'b0; rt_nez = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_mem_rd", 8'(mem_rd), 8'd0);
    chk("rst_ir_we", 8'(ir_we), 8'd0);
    chk("rst_pulses", 8'({instr_done, illegal, timeout}), 8'd0);
    reset_n = 1'b1;
    mem_ready = 1'b0;

    rtype("addu", 6'b100001, 3'b000);
    rtype("subu", 6'b100011, 3'b001);
    rtype("or", 6'b100101, 3'b011);
    imm("ori", 6'b001101, 3'b011);
    imm("lui", 6'b001111, 3'b100);

    // lw with three wait cycles in MEM: 8 cycles total
    op = 6'b100011; func = 6'b000000;
    f_exp("lw_f", 1'b1); d_exp("lw_d"); e_mem("lw_e");
    m_exp("lw_m0", 1'b1, 1'b0); m_exp("lw_m1", 1'b1, 1'b0);
    m_exp("lw_m2", 1'b1, 1'b0); m_exp("lw_m3", 1'b1, 1'b1);
    ex(3'd4); set_reg(2'b00, 2'b01); push("lw_w", 1'b1);
    pend_done = 1'b1;
    drain();

    op = 6'b101011;
    f_exp("sw_f", 1'b1); d_exp("sw_d"); e_mem("sw_e");
    m_exp("sw_m", 1'b0, 1'b1);
    pend_done = 1'b1;
    drain();

    beq("beq_t", 1'b1);
    beq("beq_nt", 1'b0);
    jump("j", 6'b000010, 6'b000000, 2'b10, 1'b0);
    jump("jal", 6'b000011, 6'b000000, 2'b10, 1'b1);
    jump("jr", 6'b000000, 6'b001000, 2'b11, 1'b0);

    // nop with a two-cycle fetch stall
    op = 6'b000000; func = 6'b000000;
    f_exp("nop_f0", 1'b0); f_exp("nop_f1", 1'b0); f_exp("nop_f2", 1'b1);
    d_exp("nop_d");
    pend_done = 1'b1;
    drain();

    bad("ill_op", 6'b111111, 6'b000000, 5'd0);
    bad("ill_fn", 6'b000000, 6'b100000, 5'd0);

`ifdef BNEZALC_EN
    op = 6'b000001; func = 6'b000000; rt = 5'b10011;
    for (int k = 0; k < 2; k++) begin
      nez_s = (k == 1);
      f_exp("bnezalc_f", 1'b1); d_exp("bnezalc_d");
      ex(3'd2); set_reg(2'b10, 2'b10); set_pc(nez_s, 2'b01); push("bnezalc_e", 1'b1);
      pend_done = 1'b1;
      drain();
    end
    nez_s = 1'b0; rt = 5'd0;
`else
    bad("bnezalc_ill", 6'b000001, 6'b000000, 5'b10011);
`endif

    // Reset in the middle of a stalled lw MEM phase
    op = 6'b100011; func = 6'b000000;
    f_exp("rlw_f", 1'b1); d_exp("rlw_d"); e_mem("rlw_e");
    m_exp("rlw_m", 1'b1, 1'b0);
    drain();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_state", 8'(state), 8'd0);
    chk("mid_rst_reg_we", 8'(reg_we), 8'd0);
    chk("mid_rst_mem_rd", 8'(mem_rd), 8'd0);
    pend_done = 1'b0; pend_ill = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("rel_state", 8'(state), 8'd0);
    chk("rel_mem_rd", 8'(mem_rd), 8'd1);
    chk("rel_addr_sel", 8'(addr_sel), 8'd0);
    chk("rel_reg_we", 8'(reg_we), 8'd0);

    // Fetch timeout after 15 stalled cycles, then FETCH restarts
    op = 6'b000000; func = 6'b000000;
    for (int k = 0; k < 15; k++) f_exp("to_wait", 1'b0);
    exp_to = 1'b1;
    f_exp("to_after0", 1'b0); f_exp("to_after1", 1'b0);
    f_exp("to_nop_f", 1'b1); d_exp("to_nop_d");
    pend_done = 1'b1;
    f_exp("to_sticky", 1'b1);
    drain();
    reset_n = 1'b0;
    #1;
    chk("to_cleared", 8'(timeout), 8'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
